// File: rtl/text_console_pkg.sv
// Shared constants, FSM state type and default geometry for the text console writer.
package text_console_pkg;

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    localparam int unsigned DEF_COLS = 32;
    localparam int unsigned DEF_ROWS = 32;
    localparam int unsigned COL_W    = $clog2(DEF_COLS);
    localparam int unsigned ROW_W    = $clog2(DEF_ROWS);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StClear,
        StScrollRd,
        StScrollWr,
        StScrollFill
    } tc_state_e;

    function automatic logic is_ctrl(input logic [7:0] code);
        return (code == CC_BS) || (code == CC_LF) || (code == CC_FF) || (code == CC_CR);
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Character stream, RAM write port and status bundle of the text console writer.
interface text_console_writer_if #(
    parameter int unsigned COL_W = text_console_pkg::COL_W,
    parameter int unsigned ROW_W = text_console_pkg::ROW_W
);
    localparam int unsigned ADDR_W = COL_W + ROW_W;

    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_rdata;
    logic [7:0]        ram_wdata;
    logic              ram_we;
    logic [ROW_W-1:0]  cursor_row;
    logic [COL_W-1:0]  cursor_col;
    logic              busy;

    modport master (
        output char_in, char_valid, ram_rdata,
        input  char_ready, ram_addr, ram_wdata, ram_we, cursor_row, cursor_col, busy
    );

    modport slave (
        input  char_in, char_valid, ram_rdata,
        output char_ready, ram_addr, ram_wdata, ram_we, cursor_row, cursor_col, busy
    );

endinterface

// File: rtl/console_cursor.sv
// Row/column cursor with advance, newline, carriage return, backspace and home controls.
module console_cursor #(
    parameter int unsigned COL_W     = 5,
    parameter int unsigned ROW_W     = 5,
    parameter bit          HOLD_LAST = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_adv,
    input  logic             i_lf,
    input  logic             i_cr,
    input  logic             i_bs,
    input  logic             i_home,
    output logic [ROW_W-1:0] o_row,
    output logic [COL_W-1:0] o_col,
    output logic             o_ovf
);

    logic [ROW_W-1:0] r_row;
    logic [COL_W-1:0] r_col;
    logic             w_row_last;
    logic             w_col_last;
    logic [ROW_W-1:0] w_row_next;

    assign w_row_last = (r_row == '1);
    assign w_col_last = (r_col == '1);
    // Bottom row either wraps to the top or stays put while the caller scrolls.
    assign w_row_next = w_row_last ? (HOLD_LAST ? r_row : '0) : r_row + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_home) begin
            r_row <= '0;
            r_col <= '0;
        end else if (i_adv) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_next;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end else if (i_lf) begin
            r_col <= '0;
            r_row <= w_row_next;
        end else if (i_cr) begin
            r_col <= '0;
        end else if (i_bs && (r_col != '0)) begin
            r_col <= r_col - 1'b1;
        end
    end

    assign o_row = r_row;
    assign o_col = r_col;
    assign o_ovf = w_row_last && ((i_adv && w_col_last) || i_lf);

endmodule

// File: rtl/text_console_writer.sv
// Write-side producer for the tile text display: cursor, control codes, clear and scroll sweeps.
// Define TEXT_CONSOLE_SCROLL_EN to scroll up one row on bottom overflow instead of wrapping.
module text_console_writer
    import text_console_pkg::*;
#(
    parameter int unsigned COLS      = 32,
    parameter int unsigned ROWS      = 32,
    parameter logic [7:0]  FILL_CHAR = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    text_console_writer_if.slave  bus
);

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned AW = CW + RW;

    localparam logic [AW-1:0] LAST_ADDR  = AW'(ROWS * COLS - 1);
    localparam logic [AW-1:0] LAST_SRC   = AW'((ROWS - 1) * COLS - 1);
    localparam logic [AW-1:0] FIRST_FILL = AW'((ROWS - 1) * COLS);
    localparam logic [AW-1:0] ROW_STEP   = AW'(COLS);

`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam bit SCROLL_EN = 1'b1;
`else
    localparam bit SCROLL_EN = 1'b0;
`endif

    tc_state_e     r_state;
    logic [AW-1:0] r_addr;
    logic [AW-1:0] r_sweep;
    logic [7:0]    r_wdata;
    logic          r_we;
    logic          r_busy;
    logic          r_scroll_pend;

    logic          w_xfer;
    logic          w_print;
    logic [RW-1:0] w_row;
    logic [CW-1:0] w_col;
    logic          w_ovf;
    logic          w_home;

    assign w_xfer  = bus.char_valid && bus.char_ready;
    assign w_print = w_xfer && !is_ctrl(bus.char_in);
    assign w_home  = (r_state == StClear) && (r_addr == LAST_ADDR);

    console_cursor #(
        .COL_W     (CW),
        .ROW_W     (RW),
        .HOLD_LAST (SCROLL_EN)
    ) u_cursor (
        .clk    (clk),
        .reset  (reset),
        .i_adv  (w_print),
        .i_lf   (w_xfer && (bus.char_in == CC_LF)),
        .i_cr   (w_xfer && (bus.char_in == CC_CR)),
        .i_bs   (w_xfer && (bus.char_in == CC_BS)),
        .i_home (w_home),
        .o_row  (w_row),
        .o_col  (w_col),
        .o_ovf  (w_ovf)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StIdle;
            r_addr        <= '0;
            r_sweep       <= '0;
            r_wdata       <= '0;
            r_we          <= 1'b0;
            r_busy        <= 1'b0;
            r_scroll_pend <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_print) begin
                        r_state       <= StWrite;
                        r_addr        <= {w_row, w_col};
                        r_wdata       <= bus.char_in;
                        r_we          <= 1'b1;
                        r_scroll_pend <= SCROLL_EN && w_ovf;
                    end else if (w_xfer && (bus.char_in == CC_FF)) begin
                        r_state <= StClear;
                        r_addr  <= '0;
                        r_wdata <= FILL_CHAR;
                        r_we    <= 1'b1;
                        r_busy  <= 1'b1;
                    end else if (w_xfer && (bus.char_in == CC_LF) && SCROLL_EN && w_ovf) begin
                        r_state <= StScrollRd;
                        r_addr  <= ROW_STEP;
                        r_sweep <= '0;
                        r_busy  <= 1'b1;
                    end
                end
                StWrite: begin
                    r_we          <= 1'b0;
                    r_scroll_pend <= 1'b0;
                    if (r_scroll_pend) begin
                        r_state <= StScrollRd;
                        r_addr  <= ROW_STEP;
                        r_sweep <= '0;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StClear: begin
                    if (r_addr == LAST_ADDR) begin
                        r_state <= StIdle;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                StScrollRd: begin
                    r_state <= StScrollWr;
                    r_addr  <= r_sweep;
                    r_we    <= 1'b1;
                end
                // Read of row r+1 lands one cycle later; it is copied straight into row r.
                StScrollWr: begin
                    if (r_sweep == LAST_SRC) begin
                        r_state <= StScrollFill;
                        r_addr  <= FIRST_FILL;
                        r_wdata <= FILL_CHAR;
                    end else begin
                        r_state <= StScrollRd;
                        r_sweep <= r_sweep + 1'b1;
                        r_addr  <= r_sweep + ROW_STEP + AW'(1);
                        r_we    <= 1'b0;
                    end
                end
                StScrollFill: begin
                    if (r_addr == LAST_ADDR) begin
                        r_state <= StIdle;
                        r_we    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_addr <= r_addr + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.char_ready = (r_state == StIdle) && !reset;
    assign bus.ram_addr   = r_addr;
    assign bus.ram_we     = r_we;
    assign bus.ram_wdata  = (r_state == StScrollWr) ? bus.ram_rdata : r_wdata;
    assign bus.busy       = r_busy;
    assign bus.cursor_row = w_row;
    assign bus.cursor_col = w_col;

endmodule

// File: tb/tb_text_console_writer.sv
// Directed self-checking bench for text_console_writer with a synchronous RAM model.
module tb_text_console_writer;

    logic clk;
    logic reset;
    logic preload;
    logic [7:0] mem [1024];
    int unsigned we_cnt;
    int unsigned n_checks;
    int unsigned n_errors;

    text_console_writer_if #(.COL_W(5), .ROW_W(5)) bus ();

    text_console_writer #(
        .COLS      (32),
        .ROWS      (32),
        .FILL_CHAR (8'h00)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: preload fills each cell with its row index.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 8'(i >> 5);
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_wdata;
        end
        bus.ram_rdata <= mem[bus.ram_addr];
        if (bus.ram_we) we_cnt <= we_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] code);
        int n = 0;
        while (!bus.char_ready && n < 3000) begin
            step();
            n++;
        end
        if (n >= 3000) check_eq("ready_timeout", 32'(n), 32'd0);
        bus.char_in    = code;
        bus.char_valid = 1'b1;
        step();
        bus.char_valid = 1'b0;
    endtask

    task automatic do_preload();
        preload = 1'b1;
        step();
        preload = 1'b0;
    endtask

    initial begin
        int bad;
        int n;
        int unsigned snap;

        n_checks = 0;
        n_errors = 0;
        we_cnt = 0;
        preload = 1'b0;
        reset = 1'b1;
        bus.char_in = 8'h00;
        bus.char_valid = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'hFF;

        // Reset values
        #3;
        check_eq("rst_we", 32'(bus.ram_we), 32'd0);
        check_eq("rst_addr", 32'(bus.ram_addr), 32'd0);
        check_eq("rst_wdata", 32'(bus.ram_wdata), 32'd0);
        check_eq("rst_ready", 32'(bus.char_ready), 32'd0);
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_cursor", {bus.cursor_row, bus.cursor_col}, 32'd0);
        step();
        reset = 1'b0;
        #1;
        check_eq("ready_after_rst", 32'(bus.char_ready), 32'd1);

        // First printable
        send(8'h35);
        check_eq("w1_we", 32'(bus.ram_we), 32'd1);
        check_eq("w1_addr", 32'(bus.ram_addr), 32'd0);
        check_eq("w1_wdata", 32'(bus.ram_wdata), 32'h35);
        check_eq("w1_cursor", {bus.cursor_row, bus.cursor_col}, {5'd0, 5'd1});
        check_eq("w1_ready_low", 32'(bus.char_ready), 32'd0);
        step();
        check_eq("w1_ready_back", 32'(bus.char_ready), 32'd1);
        check_eq("w1_we_drop", 32'(bus.ram_we), 32'd0);

        // Rest of row 0
        bad = 0;
        for (int i = 1; i < 32; i++) begin
            send(8'(8'h40 + i));
            if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'(i) || bus.ram_wdata !== 8'(8'h40 + i))
                bad++;
        end
        check_eq("row0_writes", 32'(bad), 32'd0);
        check_eq("row0_end_cursor", {bus.cursor_row, bus.cursor_col}, {5'd1, 5'd0});

        // Control codes from 3,7
        send(8'h0A);
        send(8'h0A);
        for (int i = 0; i < 7; i++) send(8'h61);
        step();
        check_eq("pos_3_7", {bus.cursor_row, bus.cursor_col}, {5'd3, 5'd7});
        snap = we_cnt;
        send(8'h08);
        check_eq("bs_cursor", {bus.cursor_row, bus.cursor_col}, {5'd3, 5'd6});
        check_eq("bs_ready", 32'(bus.char_ready), 32'd1);
        send(8'h0D);
        check_eq("cr_cursor", {bus.cursor_row, bus.cursor_col}, {5'd3, 5'd0});
        send(8'h08);
        check_eq("bs_col0_cursor", {bus.cursor_row, bus.cursor_col}, {5'd3, 5'd0});
        send(8'h0A);
        check_eq("lf_cursor", {bus.cursor_row, bus.cursor_col}, {5'd4, 5'd0});
        step();
        check_eq("ctrl_no_writes", we_cnt - snap, 32'd0);

        // Clear screen sweep
        send(8'h0C);
        n = 0;
        bad = 0;
        while (bus.busy && n < 3000) begin
            if (bus.ram_we !== 1'b1 || bus.ram_addr !== 10'(n) || bus.ram_wdata !== 8'h00 ||
                bus.char_ready !== 1'b0)
                bad++;
            n++;
            step();
        end
        check_eq("clr_busy_cycles", 32'(n), 32'd1024);
        check_eq("clr_write_pattern", 32'(bad), 32'd0);
        check_eq("clr_cursor", {bus.cursor_row, bus.cursor_col}, 32'd0);
        check_eq("clr_we_after", 32'(bus.ram_we), 32'd0);
        bad = 0;
        for (int i = 0; i < 1024; i++) if (mem[i] !== 8'h00) bad++;
        check_eq("clr_mem", 32'(bad), 32'd0);

        // Bottom-row overflow on newline from 31,5
        for (int i = 0; i < 31; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h41);
        step();
        check_eq("pos_31_5", {bus.cursor_row, bus.cursor_col}, {5'd31, 5'd5});
`ifdef TEXT_CONSOLE_SCROLL_EN
        do_preload();
        send(8'h0A);
        n = 0;
        while (bus.busy && n < 5000) begin
            n++;
            step();
        end
        check_eq("scr_busy_cycles", 32'(n), 32'd2016);
        check_eq("scr_cursor", {bus.cursor_row, bus.cursor_col}, {5'd31, 5'd0});
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if ((i >> 5) < 31) begin
                if (mem[i] !== 8'((i >> 5) + 1)) bad++;
            end else if (mem[i] !== 8'h00) begin
                bad++;
            end
        end
        check_eq("scr_mem", 32'(bad), 32'd0);
`else
        snap = we_cnt;
        send(8'h0A);
        check_eq("wrap_cursor", {bus.cursor_row, bus.cursor_col}, 32'd0);
        check_eq("wrap_busy", 32'(bus.busy), 32'd0);
        step();
        check_eq("wrap_no_writes", we_cnt - snap, 32'd0);
`endif

        // Reset in the middle of a clear
        do_preload();
        send(8'h0C);
        n = 0;
        while (bus.ram_addr !== 10'd500 && n < 3000) begin
            n++;
            step();
        end
        check_eq("clr_reach_500", 32'(bus.ram_addr), 32'd500);
        reset = 1'b1;
        #1;
        check_eq("abort_we", 32'(bus.ram_we), 32'd0);
        check_eq("abort_cursor", {bus.cursor_row, bus.cursor_col}, 32'd0);
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        step();
        reset = 1'b0;
        #1;
        check_eq("abort_idle_ready", 32'(bus.char_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (i < 500) begin
                if (mem[i] !== 8'h00) bad++;
            end else if (mem[i] !== 8'(i >> 5)) begin
                bad++;
            end
        end
        check_eq("abort_mem", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/text_console_writer.md
Name: text_console_writer

Overview:
- Upstream producer for the tile-based text display; owns the write side of the 32x32 character RAM read by the video stage.
- Accepts one character code per valid/ready handshake and keeps a cursor.
- Writes printable codes at the cursor; interprets a small set of control codes (newline, carriage return, backspace, clear-screen).
- Optionally scrolls the screen up one row when the cursor runs off the bottom.

Parameters:
- COLS, 32, characters per row; power of two.
- ROWS, 32, rows per screen; power of two.
- FILL_CHAR, 8'h00, code written by clear and scroll fill.

Ports:
- clk  in  1  pixel clock (clk25 domain of the display)
- reset  in  1  asynchronous, active-high reset
- char_in  in  8  character code
- char_valid  in  1  char_in is valid
- char_ready  out  1  block can accept a character this cycle
- ram_addr  out  10  RAM address {row, col}, width log2(COLS)+log2(ROWS)
- ram_rdata  in  8  synchronous RAM read data; valid one cycle after ram_addr
- ram_wdata  out  8  RAM write data
- ram_we  out  1  RAM write enable
- cursor_row  out  5  current row
- cursor_col  out  5  current column
- busy  out  1  high during a clear or scroll sweep

Behaviour:
- Reset (async, active-high), all outputs: state IDLE, cursor 0,0, ram_we=0, ram_addr=0, ram_wdata=0, char_ready=0 while reset is asserted, busy=0.
- Reset mid-sweep: abort immediately; RAM contents are left partially updated.
- Handshake:
  - char_ready=1 only in IDLE.
  - A transfer occurs on a clock edge where char_valid && char_ready.
  - char_in is captured on that edge.
- FSM states: IDLE, WRITE, CLEAR, SCROLL_RD, SCROLL_WR, SCROLL_FILL.
- Printable code (any code except 0x08, 0x0A, 0x0C, 0x0D), IDLE -> WRITE:
  - In WRITE: ram_we=1, ram_addr={row,col}, ram_wdata=code, for exactly one cycle.
  - Cursor advances on the same edge: col+1; at col=COLS-1, col=0 and row+1 (row-overflow rule below).
  - Then back to IDLE. Throughput: 1 char per 2 cycles.
- 0x0D (CR): col=0; no RAM write; stays IDLE, accepts again next cycle.
- 0x0A (LF): col=0, row+1 with row-overflow rule; no write.
- 0x08 (BS): if col>0 then col-1, else no change; no erase, no write.
- 0x0C (FF), IDLE -> CLEAR:
  - busy=1; ram_we=1 with ram_wdata=FILL_CHAR at addresses 0..ROWS*COLS-1, one per cycle (1024 cycles).
  - On the last write: cursor=0,0, -> IDLE.
- Row overflow (row would exceed ROWS-1): see Optional Feature.
- Address arithmetic: ram_addr = {row, col} concatenation; counters wrap modulo their width.
- Only this block drives the RAM write port; the display keeps the read port.

Optional Feature:
- Macro: TEXT_CONSOLE_SCROLL_EN.
- Without macro: row overflow wraps row to 0, col per rule above; no RAM traffic.
- With macro: row overflow keeps row=ROWS-1 and enters the scroll sweep (busy=1).
  - For a = 0 .. (ROWS-1)*COLS-1:
    - SCROLL_RD: ram_addr=a+COLS, ram_we=0.
    - SCROLL_WR: ram_addr=a, ram_wdata=ram_rdata, ram_we=1.
  - SCROLL_FILL: writes FILL_CHAR to the last row, COLS cycles.
  - Then -> IDLE. Total 2*992+32 = 2016 cycles at defaults.
  - A printable char at col=COLS-1,row=ROWS-1 is written before the scroll starts.

Decomposition:
- Package text_console_pkg: control-code constants (CC_BS=8'h08, CC_LF=8'h0A, CC_FF=8'h0C, CC_CR=8'h0D), state enum, COL_W/ROW_W derived widths.
- One sub-module, console_cursor: row/col registers with advance/newline/CR/BS/home inputs; emits an overflow pulse.
- The FSM and sweep address counter stay in the top module.

Test Plan:
- Reset, then send 0x35 at cursor 0,0 -> one cycle later ram_we=1, ram_addr=0, ram_wdata=0x35; cursor becomes 0,1; char_ready high again on the 2nd cycle.
- Send 32 printable chars from 0,0 -> writes at addresses 0..31; cursor ends at row 1, col 0.
- At cursor 3,7: send 0x08 -> 3,6; 0x0D -> 3,0; 0x08 at col 0 -> stays 3,0; 0x0A -> 4,0; no ram_we pulses.
- Send 0x0C -> busy high for exactly 1024 cycles; ram_we=1 every cycle, addresses 0..1023, data FILL_CHAR; char_ready low throughout; cursor 0,0 after.
- Without macro: at cursor 31,5 send 0x0A -> cursor 0,0, no writes. With TEXT_CONSOLE_SCROLL_EN, using a RAM model preloaded with row index in each cell: same stimulus -> 2016 busy cycles; cell (r,c) holds r+1 for r<31; row 31 holds FILL_CHAR; cursor 31,0.
- Assert reset during a clear at address 500 -> ram_we drops immediately, cursor 0,0; state IDLE after release; addresses 500..1023 keep their old contents.
